// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: forwarding selects, hazard causes and the
// hardwired-zero register index.
package pipe_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_e;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'b00,
        CAUSE_LDUSE = 2'b01,
        CAUSE_MDU   = 2'b10,
        CAUSE_JR    = 2'b11
    } cause_e;

    // Per-cycle pipeline action chosen by the hazard priority logic.
    typedef enum logic [1:0] {
        ACT_RUN   = 2'b00,
        ACT_STALL = 2'b01,
        ACT_JR    = 2'b10
    } action_e;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Saturating increment for the debug statistics counters.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// EX-stage operand forwarding select for one source register.
// A newer result in MEM takes priority over an older one in WB;
// writes to register 0 are never forwarded.
module fwd_sel
    import pipe_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] mem_dest,
    input  logic       mem_reg_wen,
    input  logic [4:0] wb_dest,
    input  logic       wb_reg_wen,
    output logic [1:0] fwd
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_reg_wen && (mem_dest != REG_ZERO) && (mem_dest == src);
    assign wb_hit  = wb_reg_wen  && (wb_dest  != REG_ZERO) && (wb_dest  == src);

    // Priority select: MEM, then WB, then register file.
    always_comb begin
        fwd = FWD_RF;
        if (mem_hit) begin
            fwd = FWD_MEM;
        end else if (wb_hit) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: PC / IF-ID / ID-EX sequencing for load-use
// and HI/LO-not-ready stalls, jr wrong-path squash, EX operand forwarding,
// and saturating stall/flush statistics.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MDU_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_reads_hilo,
    input  logic        id_mdu_op,
    input  logic [4:0]  ex_rs,
    input  logic [4:0]  ex_rt,
    input  logic [4:0]  ex_dest,
    input  logic        ex_reg_wen,
    input  logic        ex_dmem_alu,
    input  logic        ex_jr,
    input  logic        ex_mdu_start,
    input  logic [4:0]  mem_dest,
    input  logic [4:0]  wb_dest,
    input  logic        mem_reg_wen,
    input  logic        wb_reg_wen,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        mdu_busy,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic [1:0]  last_cause
);

    localparam logic [3:0] MDU_LOAD = 4'(MDU_LAT);

    logic [3:0]  mdu_cnt_q,    mdu_cnt_d;
    logic [15:0] stall_cnt_q,  stall_cnt_d;
    logic [15:0] flush_cnt_q,  flush_cnt_d;
    logic [1:0]  last_cause_q, last_cause_d;

    logic        ld_use;
    logic        mdu_haz;
    action_e     action;
    logic [1:0]  fwd_a_raw;
    logic [1:0]  fwd_b_raw;

    assign mdu_busy = (mdu_cnt_q != 4'd0);

    // Hazard detection against the instruction currently in EX.
    always_comb begin
        ld_use = 1'b0;
        if (ex_reg_wen && ex_dmem_alu && (ex_dest != REG_ZERO)) begin
            ld_use = (id_uses_rs && (id_rs == ex_dest)) ||
                     (id_uses_rt && (id_rt == ex_dest));
        end
        mdu_haz = mdu_busy && (id_reads_hilo || id_mdu_op);
    end

    // Priority resolution: a resolving jr squashes the stalled instruction
    // anyway, so it overrides any stall request.
    always_comb begin
        action = ACT_RUN;
        if (ex_jr) begin
            action = ACT_JR;
        end else if (ld_use || mdu_haz) begin
            action = ACT_STALL;
        end
    end

    // Pipeline enables; reset holds the front end frozen and both pipes cleared.
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (rst) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            case (action)
                ACT_JR: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
                ACT_STALL: begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    fwd_sel u_fwd_a (
        .src         (ex_rs),
        .mem_dest    (mem_dest),
        .mem_reg_wen (mem_reg_wen),
        .wb_dest     (wb_dest),
        .wb_reg_wen  (wb_reg_wen),
        .fwd         (fwd_a_raw)
    );

    fwd_sel u_fwd_b (
        .src         (ex_rt),
        .mem_dest    (mem_dest),
        .mem_reg_wen (mem_reg_wen),
        .wb_dest     (wb_dest),
        .wb_reg_wen  (wb_reg_wen),
        .fwd         (fwd_b_raw)
    );

    assign fwd_a = rst ? FWD_RF : fwd_a_raw;
    assign fwd_b = rst ? FWD_RF : fwd_b_raw;

    // Next-state for the MDU latency counter and the debug statistics.
    // The MDU count survives a jr: the mult/div has already issued.
    always_comb begin
        mdu_cnt_d    = mdu_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        last_cause_d = last_cause_q;

        if (ex_mdu_start) begin
            mdu_cnt_d = MDU_LOAD;
        end else if (mdu_cnt_q != 4'd0) begin
            mdu_cnt_d = mdu_cnt_q - 4'd1;
        end

        case (action)
            ACT_JR: begin
                flush_cnt_d  = sat_inc(flush_cnt_q);
                last_cause_d = CAUSE_JR;
            end
            ACT_STALL: begin
                stall_cnt_d  = sat_inc(stall_cnt_q);
                last_cause_d = ld_use ? CAUSE_LDUSE : CAUSE_MDU;
            end
            default: ;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mdu_cnt_q    <= 4'd0;
            stall_cnt_q  <= 16'd0;
            flush_cnt_q  <= 16'd0;
            last_cause_q <= CAUSE_NONE;
        end else begin
            mdu_cnt_q    <= mdu_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            last_cause_q <= last_cause_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign last_cause = last_cause_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_dest, mem_dest, wb_dest;
    logic        id_uses_rs, id_uses_rt, id_reads_hilo, id_mdu_op;
    logic        ex_reg_wen, ex_dmem_alu, ex_jr, ex_mdu_start;
    logic        mem_reg_wen, wb_reg_wen;
    logic        pc_en, if_id_en, if_id_flush, id_ex_flush, mdu_busy;
    logic [1:0]  fwd_a, fwd_b, last_cause;
    logic [15:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MDU_LAT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rs    (id_uses_rs),
        .id_uses_rt    (id_uses_rt),
        .id_reads_hilo (id_reads_hilo),
        .id_mdu_op     (id_mdu_op),
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .ex_dest       (ex_dest),
        .ex_reg_wen    (ex_reg_wen),
        .ex_dmem_alu   (ex_dmem_alu),
        .ex_jr         (ex_jr),
        .ex_mdu_start  (ex_mdu_start),
        .mem_dest      (mem_dest),
        .wb_dest       (wb_dest),
        .mem_reg_wen   (mem_reg_wen),
        .wb_reg_wen    (wb_reg_wen),
        .pc_en         (pc_en),
        .if_id_en      (if_id_en),
        .if_id_flush   (if_id_flush),
        .id_ex_flush   (id_ex_flush),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .mdu_busy      (mdu_busy),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt),
        .last_cause    (last_cause)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic idle_inputs();
        id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_reads_hilo = 0; id_mdu_op = 0;
        ex_rs = 0; ex_rt = 0; ex_dest = 0;
        ex_reg_wen = 0; ex_dmem_alu = 0; ex_jr = 0; ex_mdu_start = 0;
        mem_dest = 0; wb_dest = 0; mem_reg_wen = 0; wb_reg_wen = 0;
    endtask

    task automatic set_load_use(input logic [4:0] d);
        ex_dest = d; ex_reg_wen = 1; ex_dmem_alu = 1;
        id_rs = 5; id_uses_rs = 1;
    endtask

    // Advance one clock; inputs change and outputs are sampled on negedges.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin : stim
        int stalls;
        int busy;

        idle_inputs();
        rst = 1;
        // Forwarding would hit, but reset must force register-file select.
        ex_rs = 7; mem_dest = 7; mem_reg_wen = 1;
        ex_mdu_start = 1;
        step(); step();
        #1;
        check("rst_pc_en",       pc_en,       0);
        check("rst_if_id_en",    if_id_en,    0);
        check("rst_if_id_flush", if_id_flush, 1);
        check("rst_id_ex_flush", id_ex_flush, 1);
        check("rst_fwd_a",       fwd_a,       0);
        check("rst_mdu_busy",    mdu_busy,    0);
        check("rst_stall_cnt",   stall_cnt,   0);
        check("rst_flush_cnt",   flush_cnt,   0);
        check("rst_last_cause",  last_cause,  0);

        // Load-use hazard on r5
        step(); rst = 0; idle_inputs(); set_load_use(5); #1;
        check("lu_pc_en",       pc_en,       0);
        check("lu_if_id_en",    if_id_en,    0);
        check("lu_id_ex_flush", id_ex_flush, 1);
        check("lu_if_id_flush", if_id_flush, 0);
        step(); idle_inputs(); #1;
        check("lu_stall_cnt",   stall_cnt,   1);
        check("lu_last_cause",  last_cause,  1);
        check("lu_release",     pc_en,       1);

        // Load targeting r0 is never a hazard
        set_load_use(0); ex_dest = 0; id_rs = 0; #1;
        check("lu0_pc_en",       pc_en,       1);
        check("lu0_id_ex_flush", id_ex_flush, 0);
        step(); idle_inputs(); #1;
        check("lu0_stall_cnt",   stall_cnt,   1);

        // jr overrides a simultaneous load-use stall
        set_load_use(5); ex_jr = 1; #1;
        check("jr_pc_en",       pc_en,       1);
        check("jr_if_id_en",    if_id_en,    1);
        check("jr_if_id_flush", if_id_flush, 1);
        check("jr_id_ex_flush", id_ex_flush, 1);
        step(); idle_inputs(); #1;
        check("jr_flush_cnt",   flush_cnt,   1);
        check("jr_stall_cnt",   stall_cnt,   1);
        check("jr_last_cause",  last_cause,  3);

        // MDU wait: mfhi held in ID while a mult runs with latency 4
        ex_mdu_start = 1; id_reads_hilo = 1; #1;
        check("mdu_issue_pc_en", pc_en, 1);
        step(); ex_mdu_start = 0; #1;
        stalls = 0;
        for (int i = 0; i < 10; i++) begin
            if (pc_en) break;
            stalls++;
            step(); #1;
        end
        check("mdu_stall_cycles", stalls, 4);
        check("mdu_busy_clear",   mdu_busy, 0);
        check("mdu_stall_cnt",    stall_cnt, 5);
        check("mdu_last_cause",   last_cause, 2);

        // Simultaneous load-use and MDU hazard records load-use
        step(); idle_inputs(); ex_mdu_start = 1;
        step(); idle_inputs(); set_load_use(5); id_mdu_op = 1; #1;
        check("both_mdu_busy", mdu_busy, 1);
        check("both_pc_en",    pc_en,    0);
        step(); idle_inputs(); #1;
        check("both_last_cause", last_cause, 1);
        for (int i = 0; i < 6; i++) step();

        // Back-to-back mdu start reloads: busy for 1 + 4 cycles after first start
        idle_inputs(); ex_mdu_start = 1;
        step(); #1;
        busy = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) ex_mdu_start = 1; else ex_mdu_start = 0;
            if (!mdu_busy) break;
            busy++;
            step(); #1;
        end
        check("mdu_reload_busy", busy, 5);

        // Forwarding priority
        idle_inputs();
        ex_rs = 7; mem_dest = 7; wb_dest = 7; mem_reg_wen = 1; wb_reg_wen = 1; #1;
        check("fwd_a_mem", fwd_a, 2);
        mem_reg_wen = 0; #1;
        check("fwd_a_wb", fwd_a, 1);
        mem_reg_wen = 1; mem_dest = 0; wb_dest = 0; ex_rs = 0; #1;
        check("fwd_a_zero", fwd_a, 0);
        ex_rs = 3; ex_rt = 4; wb_dest = 3; mem_dest = 4; #1;
        check("fwd_a_split", fwd_a, 1);
        check("fwd_b_split", fwd_b, 2);
        ex_rt = 9; #1;
        check("fwd_b_none", fwd_b, 0);

        // Saturation of stall_cnt
        step(); idle_inputs(); set_load_use(5);
        for (int i = 0; i < 70000; i++) step();
        #1;
        check("sat_stall_cnt", stall_cnt, 16'hFFFF);

        // Reset mid-MDU count
        idle_inputs(); ex_mdu_start = 1;
        step(); ex_mdu_start = 0; step(); #1;
        check("pre_rst_busy", mdu_busy, 1);
        rst = 1; #1;
        check("rst_hold_pc_en", pc_en, 0);
        step(); #1;
        check("rst2_mdu_busy",   mdu_busy,   0);
        check("rst2_stall_cnt",  stall_cnt,  0);
        check("rst2_flush_cnt",  flush_cnt,  0);
        check("rst2_last_cause", last_cause, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
